// File: rtl/weight_load_responder.sv
`default_nettype none
// ============================================================================
// Module  : weight_load_responder
// Brief   : On each load request, fetches one output-channel-tile weight group
//           from memory and writes it into the weight buffer, then acks.
// Rev     : 1.0
// ============================================================================
module weight_load_responder #(
    parameter int TPO     = 8,
    parameter int KS      = 3,
    parameter int BUF_AW  = 12,
    parameter int MAX_OUT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_weight_req_i,
    output logic              load_weight_ack_o,
    input  logic [31:0]       weight_base_i,
    input  logic [31:0]       ic_i,
    input  logic [31:0]       oco_i,
    output logic              mem_req_o,
    output logic [31:0]       mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              wbuf_we_o,
    output logic [BUF_AW-1:0] wbuf_addr_o,
    output logic [31:0]       wbuf_wdata_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int              c_ow      = $clog2(MAX_OUT) + 1;
    localparam logic [31:0]     c_taps    = 32'(TPO * KS * KS);
    localparam logic [32:0]     c_cap     = 33'd1 << BUF_AW;
    localparam logic [c_ow-1:0] c_max_out = c_ow'(MAX_OUT);
    localparam logic [c_ow-1:0] c_one     = c_ow'(1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StFetch = 3'd2,
        StDrain = 3'd3,
        StAck   = 3'd4,
        StGuard = 3'd5
    } state_t;

    state_t          r_state;
    logic [31:0]     r_total;
    logic [31:0]     r_grp_addr;
    logic [31:0]     r_issue_cnt;
    logic [31:0]     r_resp_cnt;
    logic [c_ow-1:0] r_outstanding;
    logic            r_err;

    logic [31:0]     w_total;
    logic [31:0]     w_grp_addr;
    logic            w_overflow;
    logic            w_grant;
    logic            w_rsp_fire;

    assign w_total    = c_taps * (ic_i >> 5);
    assign w_grp_addr = weight_base_i + oco_i * w_total * 32'd4;
    assign w_overflow = {1'b0, w_total} > c_cap;

    assign mem_req_o  = (r_state == StFetch) && (r_issue_cnt < r_total)
                        && (r_outstanding < c_max_out);
    assign mem_addr_o = mem_req_o ? (r_grp_addr + {r_issue_cnt[29:0], 2'b00}) : 32'd0;
    assign w_grant    = mem_req_o && mem_gnt_i;

    // Responses with nothing outstanding are strays (e.g. from before a reset).
    assign w_rsp_fire = ((r_state == StFetch) || (r_state == StDrain))
                        && mem_rvalid_i && (r_outstanding != '0);

    assign wbuf_we_o         = w_rsp_fire;
    assign wbuf_addr_o       = w_rsp_fire ? r_resp_cnt[BUF_AW-1:0] : '0;
    assign wbuf_wdata_o      = w_rsp_fire ? mem_rdata_i : 32'd0;
    assign load_weight_ack_o = (r_state == StAck);
    assign busy_o            = (r_state != StIdle);
    assign err_o             = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= StIdle;
            r_total       <= 32'd0;
            r_grp_addr    <= 32'd0;
            r_issue_cnt   <= 32'd0;
            r_resp_cnt    <= 32'd0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_grant)    r_issue_cnt <= r_issue_cnt + 32'd1;
            if (w_rsp_fire) r_resp_cnt  <= r_resp_cnt + 32'd1;
            if (w_grant && !w_rsp_fire)      r_outstanding <= r_outstanding + c_one;
            else if (!w_grant && w_rsp_fire) r_outstanding <= r_outstanding - c_one;

            case (r_state)
                StIdle: begin
                    if (load_weight_req_i) r_state <= StSetup;
                end
                StSetup: begin
                    r_total       <= w_total;
                    r_grp_addr    <= w_grp_addr;
                    r_issue_cnt   <= 32'd0;
                    r_resp_cnt    <= 32'd0;
                    r_outstanding <= '0;
                    r_err         <= w_overflow;
                    if ((w_total == 32'd0) || w_overflow) r_state <= StAck;
                    else                                  r_state <= StFetch;
                end
                StFetch: begin
                    // Leave on the final grant so the last response is seen in StDrain.
                    if (w_grant && (r_issue_cnt + 32'd1 == r_total)) r_state <= StDrain;
                end
                StDrain: begin
                    // Ack lands the cycle right after the final buffer write.
                    if ((w_rsp_fire && (r_resp_cnt + 32'd1 == r_total))
                        || (r_resp_cnt == r_total)) r_state <= StAck;
                end
                StAck:   r_state <= StGuard;
                StGuard: r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_weight_load_responder.sv
`default_nettype none
// Randomized scoreboard bench for weight_load_responder: expected reads, buffer
// writes and acks are queued from the load parameters and consumed by a monitor.
module tb_weight_load_responder;

    localparam int TPO     = 8;
    localparam int KS      = 3;
    localparam int BUF_AW  = 12;
    localparam int MAX_OUT = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_weight_req_i = 1'b0;
    logic              load_weight_ack_o;
    logic [31:0]       weight_base_i = '0;
    logic [31:0]       ic_i = '0;
    logic [31:0]       oco_i = '0;
    logic              mem_req_o;
    logic [31:0]       mem_addr_o;
    logic              mem_gnt_i = 1'b0;
    logic              mem_rvalid_i = 1'b0;
    logic [31:0]       mem_rdata_i = '0;
    logic              wbuf_we_o;
    logic [BUF_AW-1:0] wbuf_addr_o;
    logic [31:0]       wbuf_wdata_o;
    logic              busy_o;
    logic              err_o;

    weight_load_responder #(
        .TPO(TPO), .KS(KS), .BUF_AW(BUF_AW), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .load_weight_req_i(load_weight_req_i), .load_weight_ack_o(load_weight_ack_o),
        .weight_base_i(weight_base_i), .ic_i(ic_i), .oco_i(oco_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .wbuf_we_o(wbuf_we_o), .wbuf_addr_o(wbuf_addr_o), .wbuf_wdata_o(wbuf_wdata_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int unsigned due; logic [31:0] data; } pend_t;
    typedef struct { logic [BUF_AW-1:0] a; logic [31:0] d; } wr_t;

    pend_t       pend[$];
    logic [31:0] exp_addr[$];
    wr_t         exp_wr[$];
    bit          exp_ack[$];

    int          checks = 0;
    int          failures = 0;
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    int          stray_pct = 0;
    int          tb_out = 0;
    int unsigned grant_cnt = 0;
    int unsigned last_wr_c = 0;
    logic [31:0] seed = 32'h1234_5678;

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", nm, act, cyc);
    endtask

    // Memory model: in-order responses after a per-grant latency, optional strays when idle.
    initial begin
        forever begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = pend[0].data;
                void'(pend.pop_front());
            end else if (pend.size() == 0 && rst_n && $urandom_range(99) < stray_pct) begin
                mem_rvalid_i = 1'b1;
            end
            mem_gnt_i = ($urandom_range(99) < gnt_pct);
            #1;
            if (rst_n && mem_req_o && mem_gnt_i)
                pend.push_back('{cyc + $urandom_range(lat_max, lat_min), fdata(mem_addr_o)});
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit rv;
        bit g;
        wr_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                tb_out = 0;
                exp_addr.delete();
                exp_wr.delete();
                exp_ack.delete();
            end else begin
                rv = mem_rvalid_i && (tb_out > 0);
                g  = mem_req_o && mem_gnt_i;
                if (mem_req_o) check("req_under_limit", 64'(tb_out < MAX_OUT), 64'd1);
                if (g) begin
                    grant_cnt++;
                    if (exp_addr.size() == 0) fail_now("unexpected_read", 64'(mem_addr_o));
                    else check("read_addr", 64'(mem_addr_o), 64'(exp_addr.pop_front()));
                end
                if (rv || wbuf_we_o) check("write_on_rvalid", 64'(wbuf_we_o), 64'(rv));
                if (wbuf_we_o) begin
                    last_wr_c = cyc;
                    if (exp_wr.size() == 0) fail_now("unexpected_write", 64'(wbuf_addr_o));
                    else begin
                        e = exp_wr.pop_front();
                        check("wbuf_addr", 64'(wbuf_addr_o), 64'(e.a));
                        check("wbuf_data", 64'(wbuf_wdata_o), 64'(e.d));
                    end
                end
                if (load_weight_ack_o) begin
                    if (exp_ack.size() == 0) fail_now("unexpected_ack", 64'(err_o));
                    else check("err_at_ack", 64'(err_o), 64'(exp_ack.pop_front()));
                end
                tb_out = tb_out + int'(g) - int'(rv);
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, 64'({load_weight_ack_o, mem_req_o, wbuf_we_o, busy_o, err_o}), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr_o), 64'd0);
        check({tag, "_wbuf_addr"}, 64'(wbuf_addr_o), 64'd0);
        check({tag, "_wbuf_wdata"}, 64'(wbuf_wdata_o), 64'd0);
    endtask

    // Reference: a group is TPO*KS*KS*(ic/32) consecutive words starting at
    // base + oco*total*4; buffer word i holds memory word i of the group.
    task automatic push_expect(input logic [31:0] base, input logic [31:0] ic,
                               input logic [31:0] oco, output logic [31:0] total,
                               output bit ovf);
        logic [31:0] grp;
        logic [31:0] a;
        total = 32'(TPO * KS * KS) * (ic >> 5);
        grp   = base + oco * total * 32'd4;
        ovf   = (64'(total) > (64'd1 << BUF_AW));
        if (!ovf) begin
            for (int i = 0; i < int'(total); i++) begin
                a = grp + 32'(i) * 32'd4;
                exp_addr.push_back(a);
                exp_wr.push_back('{BUF_AW'(i), fdata(a)});
            end
        end
        exp_ack.push_back(ovf);
    endtask

    task automatic run_xfer(input logic [31:0] base, input logic [31:0] ic,
                            input logic [31:0] oco, input int hold);
        logic [31:0] total;
        bit ovf;
        bit seen_req;
        bit seen_ack;
        int unsigned n;
        int unsigned first_c;
        int unsigned ack_c;
        push_expect(base, ic, oco, total, ovf);
        seen_req = 0;
        seen_ack = 0;
        first_c  = 0;
        ack_c    = 0;
        @(negedge clk);
        weight_base_i = base;
        ic_i = ic;
        oco_i = oco;
        load_weight_req_i = 1'b1;
        n = cyc;
        for (int k = 0; k < 20000 && !seen_ack; k++) begin
            @(negedge clk);
            #2;
            if (mem_req_o && !seen_req) begin
                seen_req = 1;
                first_c = cyc;
            end
            if (load_weight_ack_o) begin
                seen_ack = 1;
                ack_c = cyc;
            end else if (cyc > n + 1) begin
                weight_base_i = $urandom;
                ic_i = $urandom;
                oco_i = $urandom;
            end
        end
        if (!seen_ack) fail_now("ack_timeout", 64'(busy_o));
        repeat (hold) @(negedge clk);
        load_weight_req_i = 1'b0;
        if (seen_ack) begin
            if (ovf || total == 0) begin
                check("ack_latency", 64'(ack_c), 64'(n + 2));
            end else begin
                check("first_req_latency", 64'(first_c), 64'(n + 2));
                check("ack_after_last_write", 64'(ack_c), 64'(last_wr_c + 1));
            end
        end
        repeat (3) @(negedge clk);
        #3;
        check("busy_after", 64'(busy_o), 64'd0);
        check("err_sticky", 64'(err_o), 64'(ovf));
        check("reads_left", 64'(exp_addr.size()), 64'd0);
        check("writes_left", 64'(exp_wr.size()), 64'd0);
        check("acks_left", 64'(exp_ack.size()), 64'd0);
    endtask

    task automatic reset_mid_xfer();
        logic [31:0] total;
        bit ovf;
        int unsigned g0;
        gnt_pct = 100;
        lat_min = 3;
        lat_max = 3;
        stray_pct = 0;
        push_expect(32'h1000, 32'd64, 32'd2, total, ovf);
        g0 = grant_cnt;
        @(negedge clk);
        weight_base_i = 32'h1000;
        ic_i = 32'd64;
        oco_i = 32'd2;
        load_weight_req_i = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            #3;
            if (grant_cnt - g0 >= 50) break;
        end
        if (grant_cnt - g0 < 50) fail_now("grant_timeout", 64'(grant_cnt - g0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        load_weight_req_i = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 50 && pend.size() > 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("idle_after_reset", 64'(busy_o), 64'd0);
        run_xfer(32'h1000, 32'd64, 32'd2, 1);
    endtask

    initial begin
        seed = $urandom;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        gnt_pct = 100; lat_min = 1;  lat_max = 1;
        run_xfer(32'h1000, 32'd64, 32'd2, 1);
        lat_min = 10; lat_max = 10;
        run_xfer(32'h1000, 32'd64, 32'd2, 1);
        lat_min = 1;  lat_max = 1;
        run_xfer(32'h1000, 32'd16, 32'd2, 1);
        run_xfer(32'h2000, 32'd1824, 32'd1, 1);
        run_xfer(32'h2000, 32'd0, 32'd1, 1);
        run_xfer(32'h1000, 32'd32, 32'd3, 2);
        reset_mid_xfer();

        for (int t = 0; t < 8; t++) begin
            gnt_pct   = $urandom_range(100, 30);
            lat_min   = $urandom_range(3, 1);
            lat_max   = lat_min + $urandom_range(4, 0);
            stray_pct = 20;
            run_xfer($urandom & 32'hFFFF_FFFC, 32'($urandom_range(127, 0)),
                     32'($urandom_range(15, 0)), $urandom_range(2, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/weight_load_responder.md
Name: weight_load_responder

Overview:
- Services the weight-load request/acknowledge handshake issued by the convolution loop controller.
- On each request, fetches the weight group for the current output-channel tile (TPO filters × KS×KS taps × ic/32 packed words) from memory and writes it into the weight buffer, then acknowledges.
- Sits between the loop controller, the system memory port (req/gnt/rvalid) and the weight buffer write port.

Parameters:
TPO, 8, output channels per tile (filters per group)
KS, 3, kernel width/height
BUF_AW, 12, weight buffer address width (capacity 2^BUF_AW 32-bit words)
MAX_OUT, 4, maximum outstanding memory reads (power of two, ≥1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
load_weight_req_i  in  1  level request; held high by controller until ack
load_weight_ack_o  out  1  one-cycle completion pulse
weight_base_i  in  32  byte base address of weight tensor
ic_i  in  32  input channel count (packed 32 per word)
oco_i  in  32  output-channel tile index
mem_req_o  out  1  memory read request
mem_addr_o  out  32  word-aligned byte address
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  read data valid (in order)
mem_rdata_i  in  32  read data
wbuf_we_o  out  1  buffer write enable
wbuf_addr_o  out  BUF_AW  buffer word address
wbuf_wdata_o  out  32  buffer write data
busy_o  out  1  high in any state except StIdle
err_o  out  1  sticky: last group exceeded buffer capacity

Behaviour:
- Reset: all outputs 0; state StIdle; all counters 0. Reset mid-transfer aborts immediately; late rvalids after reset are dropped (outstanding count cleared).
- total = TPO*KS*KS*(ic_i>>5), 32-bit unsigned, latched in StSetup together with weight_base_i and oco_i. Inputs are not re-sampled during a transfer.
- grp_addr = weight_base_i + oco_i*total*4, 32-bit wrap-around.
- State machine:
  - StIdle: load_weight_req_i=1 -> StSetup.
  - StSetup (1 cycle): latch values, clear counters and err_o.
    - total==0 -> StAck.
    - total>2^BUF_AW -> set err_o, no fetch -> StAck.
    - Otherwise -> StFetch.
  - StFetch:
    - mem_req_o=1 while issue_cnt<total and outstanding<MAX_OUT.
    - mem_addr_o = grp_addr + issue_cnt*4, driven combinationally from registers.
    - issue_cnt increments on mem_req_o&mem_gnt_i.
    - Leave when issue_cnt==total -> StDrain.
  - StDrain: wait until resp_cnt==total -> StAck.
  - StAck: load_weight_ack_o=1 for exactly one cycle -> StGuard.
  - StGuard (1 cycle): ignore load_weight_req_i, which the controller drops the cycle after ack -> StIdle.
- Response path, active in StFetch and StDrain:
  - On mem_rvalid_i, same cycle: wbuf_we_o=1, wbuf_addr_o=resp_cnt[BUF_AW-1:0], wbuf_wdata_o=mem_rdata_i (combinational pass-through).
  - resp_cnt then increments.
- outstanding: +1 on grant, -1 on rvalid. Both in the same cycle leaves it unchanged. Never exceeds MAX_OUT.
- gnt and rvalid may coincide, including the final grant with an earlier response.
- rvalid with outstanding==0 is ignored; no buffer write.
- Minimum latency: request sampled at t -> first mem_req_o at t+2; ack one cycle after the final buffer write.

Test Plan:
- TPO=8,KS=3,ic=64,oco=2,base=0x1000, gnt always 1, rvalid 1 cycle after gnt -> 144 reads; first addr 0x1480, last 0x16BC; wbuf addrs 0..143 with matching data; one ack pulse; err_o=0.
- Same config, rvalid delayed 10 cycles -> mem_req_o never high with 4 outstanding; all 144 words written in order; single ack.
- ic=16 (total=0) -> no mem_req_o, ack 2 cycles after request, wbuf_we_o never asserted.
- BUF_AW=6, ic=64 (total 144>64) -> err_o=1, no reads, ack issued; next request with ic=0 clears err_o in StSetup.
- Request held high 1 cycle past ack -> StGuard absorbs it; no second transfer; busy_o low afterwards.
- rst_ni asserted after 50 grants with 3 outstanding -> outputs 0 immediately; late rvalids produce no writes; a fresh request restarts at issue address grp_addr.
